// File: rtl/sha256_const_fetch.sv
// Burst fetch of SHA-256 constants from byte-wide asynchronous EEPROMs onto a valid/ready stream.
// Generates registered CE_n/OE_n timing and holds each assembled word under backpressure.
module sha256_const_fetch #(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned LANES    = 4,
  parameter int unsigned LANE_W   = 8,
  parameter int unsigned WAIT_CYC = 4,
  parameter int unsigned GAP_CYC  = 1,
  parameter int unsigned LEN_W    = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [LEN_W-1:0]          req_len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_a,
  input  logic [LANES*LANE_W-1:0]   rom_io,
  output logic                      rom_ce_n,
  output logic                      rom_oe_n,
  output logic                      rom_we_n
);

  localparam int unsigned DataW = LANES * LANE_W;
  localparam int unsigned MaxCyc = (WAIT_CYC > GAP_CYC) ? WAIT_CYC : GAP_CYC;
  localparam int unsigned CntW = (MaxCyc < 2) ? 1 : $clog2(MaxCyc);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StGap} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rom_a_q, rom_a_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [DataW-1:0]   out_data_q, out_data_d;

  always_comb begin
    state_d     = state_q;
    rom_a_d     = rom_a_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    ce_n_d      = ce_n_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      StIdle: begin
        if (req_valid && (req_len != '0)) begin
          rom_a_d     = req_addr;
          remaining_d = req_len;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        ce_n_d  = 1'b0;
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q == CntW'(WAIT_CYC - 1)) begin
          out_data_d  = rom_io;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == LEN_W'(1));
          ce_n_d      = 1'b1;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = StIdle;
          end else begin
            // Wraps modulo 2^ADDR_W; GAP doubles as address setup time.
            rom_a_d = rom_a_q + ADDR_W'(1);
            cnt_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYC - 1)) begin
          ce_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rom_a_q     <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rom_a_q     <= rom_a_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= ce_n_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign rom_a     = rom_a_q;
  assign rom_ce_n  = ce_n_q;
  assign rom_oe_n  = oe_n_q;
  assign rom_we_n  = 1'b1;

endmodule

// File: doc/sha256_const_fetch.md
# sha256_const_fetch

Parametrised fetch controller that reads SHA-256 constants (H0..H7 at word addresses 0..7, K0..K63 at 8..71) from LANES parallel byte-wide asynchronous EEPROM chips and delivers assembled words on a valid/ready stream. It sits between the constant EEPROM bank and the message-schedule/compression datapath. It replaces direct CE/OE strobing of the chips: it generates chip timing, supports bursts of consecutive words, and holds each word under backpressure.

## Interface

Parameters:
- ADDR_W, 13, EEPROM address width (8K chips)
- LANES, 4, number of byte-wide chips; lane 0 is the most-significant byte
- LANE_W, 8, data width per chip
- WAIT_CYC, 4, cycles CE_n/OE_n held low before sampling (≥1)
- GAP_CYC, 1, CE_n-high recovery cycles between burst words (≥1)
- LEN_W, 7, burst-length field width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  burst request present
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  first word address
- req_len  in  LEN_W  word count; 0 is a legal no-op
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word
- out_data  out  LANES*LANE_W  {lane0, lane1, …}
- out_last  out  1  final word of burst
- busy  out  1  high whenever state ≠ IDLE
- rom_a  out  ADDR_W  shared address to all chips (registered)
- rom_io  in  LANES*LANE_W  chip data, lane 0 in MS byte
- rom_ce_n, rom_oe_n  out  1  shared chip/output enables (registered)
- rom_we_n  out  1  tied 1; the block never writes

## Operation

- States: IDLE, SETUP, ACCESS, HOLD, GAP.
- IDLE: req_ready=1. On req_valid: len=0 → stay IDLE, nothing emitted; else load rom_a=req_addr, remaining=req_len → SETUP.
- SETUP (1 cycle): CE_n=OE_n=1, address settles → ACCESS.
- ACCESS: CE_n=OE_n=0 for exactly WAIT_CYC cycles. On the last cycle's edge, out_data←rom_io, out_valid←1, out_last←(remaining==1), CE_n/OE_n←1 → HOLD.
- HOLD: out_data/out_last stable, chip deselected. On out_valid&&out_ready: out_valid←0, remaining−1; if 0 → IDLE, else rom_a←rom_a+1 → GAP.
- GAP: CE_n=1 for GAP_CYC cycles (also address setup) → ACCESS.
- Address increments modulo 2^ADDR_W (8191 → 0).
- Requests are not accepted outside IDLE; req inputs ignored when busy.

## Timing

- Reset (async assert): state IDLE, rom_ce_n=rom_oe_n=rom_we_n=1, rom_a=0, out_valid=0, out_last=0, out_data=0, busy=0, req_ready=1. Mid-burst reset aborts immediately; the in-flight word is discarded and not re-emitted after release.
- Acceptance edge E0 → SETUP after E0; CE_n low after E1; out_valid high after E(1+WAIT_CYC) (edge 5 with defaults).
- Burst word spacing with out_ready=1: 1 (HOLD) + GAP_CYC + WAIT_CYC cycles (6 with defaults).
- CE_n never low while out_valid=1; CE_n/OE_n never glitch (registered).
- req_ready returns high the cycle after the last handshake edge; a new request may be accepted that cycle.

## Test plan

Lane models are preloaded with H at 0–7 and K at 8–71, lane 0 holding the MS byte.
- Single read: addr 0, len 1 → one word 0x6a09e667, out_last=1, out_valid first seen 5 cycles after acceptance.
- Single read: addr 8, len 1 → 0x428a2f98; CE_n low exactly 4 cycles; rom_we_n=1 throughout.
- Burst: addr 0, len 8, out_ready=1 → 0x6a09e667, 0xbb67ae85, …, 0x5be0cd19 with out_last only on the 8th word, words 6 cycles apart.
- Backpressure: addr 8, len 2, out_ready low 10 cycles → out_data holds 0x428a2f98 with CE_n=1; after release the next word is 0x71374491.
- Wrap and no-op: addr 8191, len 2 → second word read from address 0 (0x6a09e667). len 0 → no out_valid and req_ready stays 1.
- Reset mid-burst: assert rst_n low during ACCESS of word 3 → CE_n=1, out_valid=0, busy=0 asynchronously. A new request addr 8 len 1 afterward → 0x428a2f98.
